// File: rtl/mem_slave_pkg.sv
// Shared types and helpers for the HLS slave-memory initiator.
// Defines the FSM state type, the legal access sizes, and the mask/alignment helpers.
package mem_slave_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    localparam int unsigned SIZE_8  = 8;
    localparam int unsigned SIZE_16 = 16;
    localparam int unsigned SIZE_32 = 32;
    localparam int unsigned SIZE_64 = 64;
    localparam int unsigned MASK_W  = 64;

    function automatic logic is_legal_size(input int unsigned size);
        return (size == SIZE_8) || (size == SIZE_16) || (size == SIZE_32) || (size == SIZE_64);
    endfunction

    // Bit-wise compare instead of (1<<size)-1 so size 64 cannot overflow the shift.
    function automatic logic [MASK_W-1:0] size_mask(input int unsigned size);
        logic [MASK_W-1:0] m;
        for (int unsigned i = 0; i < MASK_W; i++) begin
            m[i] = (i < size);
        end
        return m;
    endfunction

    function automatic logic is_aligned(input logic [31:0] addr, input int unsigned size);
        logic ok;
        case (size)
            SIZE_8:  ok = 1'b1;
            SIZE_16: ok = (addr[0] == 1'b0);
            SIZE_32: ok = (addr[1:0] == 2'b00);
            SIZE_64: ok = (addr[2:0] == 3'b000);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_slave_timeout.sv
// Loadable down-counter for the WAIT-state timeout.
// o_expire flags the CYCLES-th enabled cycle after a load.
module mem_slave_timeout #(
    parameter int unsigned CYCLES = 256
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_expire
);

    localparam int unsigned CNT_W = $clog2(CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= CNT_W'(CYCLES);
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_expire = i_en && (r_cnt == CNT_W'(1));

endmodule

// File: rtl/mem_slave_initiator.sv
// Command/response front end for the 2-channel HLS slave memory port, one transaction in flight.
// Optional statistics counters are enabled with the SLAVE_INIT_STATS_EN macro.
module mem_slave_initiator
    import mem_slave_pkg::*;
#(
    parameter int unsigned ADDR_W         = 10,
    parameter int unsigned DATA_W         = 64,
    parameter int unsigned SIZE_W         = 7,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic                cmd_chan,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [SIZE_W-1:0]   cmd_size,
    input  logic [DATA_W-1:0]   cmd_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic [1:0]          S_oe_ram,
    output logic [1:0]          S_we_ram,
    output logic [2*ADDR_W-1:0] S_addr_ram,
    output logic [2*DATA_W-1:0] S_Wdata_ram,
    output logic [2*SIZE_W-1:0] S_data_ram_size,
    input  logic [2*DATA_W-1:0] Sout_Rdata_ram,
    input  logic [1:0]          Sout_DataRdy,
    output logic [15:0]         stat_rd_count,
    output logic [15:0]         stat_wr_count,
    output logic [15:0]         stat_to_count
);

    state_e              r_state, w_state_next;
    logic                r_chan, r_write, r_err, w_err_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [SIZE_W-1:0]   r_size;
    logic [DATA_W-1:0]   r_wdata, r_rdata, w_rdata_next;
    logic [DATA_W-1:0]   w_cmd_mask, w_rsp_mask, w_chan_rdata;
    logic                w_accept, w_legal, w_load, w_in_wait, w_done, w_expire, w_timeout;

    assign w_accept     = cmd_valid && (r_state == StIdle);
    assign w_legal      = is_legal_size(32'(cmd_size)) && is_aligned(32'(cmd_addr), 32'(cmd_size));
    assign w_load       = w_accept && w_legal;
    assign w_in_wait    = (r_state == StWait);
    assign w_done       = w_in_wait && Sout_DataRdy[r_chan];
    // Completion beats expiry when both land on the same cycle.
    assign w_timeout    = w_in_wait && !Sout_DataRdy[r_chan] && w_expire;
    assign w_cmd_mask   = DATA_W'(size_mask(32'(cmd_size)));
    assign w_rsp_mask   = DATA_W'(size_mask(32'(r_size)));
    assign w_chan_rdata = r_chan ? Sout_Rdata_ram[DATA_W +: DATA_W] : Sout_Rdata_ram[0 +: DATA_W];

    mem_slave_timeout #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk    (clock),
        .i_rst    (reset),
        .i_load   (w_load),
        .i_en     (w_in_wait),
        .o_expire (w_expire)
    );

    always_comb begin
        w_state_next = r_state;
        w_rdata_next = r_rdata;
        w_err_next   = r_err;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_rdata_next = '0;
                    w_err_next   = !w_legal;
                    w_state_next = w_legal ? StWait : StResp;
                end
            end
            StWait: begin
                if (w_done) begin
                    w_rdata_next = r_write ? '0 : (w_chan_rdata & w_rsp_mask);
                    w_err_next   = 1'b0;
                    w_state_next = StResp;
                end else if (w_timeout) begin
                    w_rdata_next = '0;
                    w_err_next   = 1'b1;
                    w_state_next = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= StIdle;
            r_chan  <= 1'b0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_size  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_rdata <= w_rdata_next;
            r_err   <= w_err_next;
            if (w_load) begin
                r_chan  <= cmd_chan;
                r_write <= cmd_write;
                r_addr  <= cmd_addr;
                r_size  <= cmd_size;
                r_wdata <= cmd_wdata & w_cmd_mask;
            end
        end
    end

    always_comb begin
        S_oe_ram        = '0;
        S_we_ram        = '0;
        S_addr_ram      = '0;
        S_Wdata_ram     = '0;
        S_data_ram_size = '0;
        if (w_in_wait) begin
            if (r_chan) begin
                S_oe_ram[1]                      = !r_write;
                S_we_ram[1]                      = r_write;
                S_addr_ram[ADDR_W +: ADDR_W]     = r_addr;
                S_Wdata_ram[DATA_W +: DATA_W]    = r_wdata;
                S_data_ram_size[SIZE_W +: SIZE_W] = r_size;
            end else begin
                S_oe_ram[0]                 = !r_write;
                S_we_ram[0]                 = r_write;
                S_addr_ram[0 +: ADDR_W]     = r_addr;
                S_Wdata_ram[0 +: DATA_W]    = r_wdata;
                S_data_ram_size[0 +: SIZE_W] = r_size;
            end
        end
    end

    assign cmd_ready = (r_state == StIdle);
    assign rsp_valid = (r_state == StResp);
    assign rsp_err   = rsp_valid && r_err;
    assign rsp_rdata = rsp_valid ? r_rdata : '0;

`ifdef SLAVE_INIT_STATS_EN
    logic [15:0] r_rd_cnt, r_wr_cnt, r_to_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
            r_to_cnt <= '0;
        end else begin
            if (w_done && !r_write && (r_rd_cnt != 16'hFFFF)) r_rd_cnt <= r_rd_cnt + 16'd1;
            if (w_done && r_write && (r_wr_cnt != 16'hFFFF))  r_wr_cnt <= r_wr_cnt + 16'd1;
            if (w_timeout && (r_to_cnt != 16'hFFFF))          r_to_cnt <= r_to_cnt + 16'd1;
        end
    end

    assign stat_rd_count = r_rd_cnt;
    assign stat_wr_count = r_wr_cnt;
    assign stat_to_count = r_to_cnt;
`else
    assign stat_rd_count = '0;
    assign stat_wr_count = '0;
    assign stat_to_count = '0;
`endif

endmodule

// File: tb/tb_mem_slave_initiator.sv
// Self-checking bench for mem_slave_initiator: directed cases then random transactions
// compared against a transaction-level model of the command/response contract.
module tb_mem_slave_initiator;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 64;
    localparam int unsigned SW = 7;
    localparam int unsigned TO = 8;

    logic            clock = 1'b0;
    logic            reset;
    logic            cmd_valid, cmd_ready, cmd_write, cmd_chan;
    logic [AW-1:0]   cmd_addr;
    logic [SW-1:0]   cmd_size;
    logic [DW-1:0]   cmd_wdata;
    logic            rsp_valid, rsp_ready, rsp_err;
    logic [DW-1:0]   rsp_rdata;
    logic [1:0]      S_oe_ram, S_we_ram, Sout_DataRdy;
    logic [2*AW-1:0] S_addr_ram;
    logic [2*DW-1:0] S_Wdata_ram, Sout_Rdata_ram;
    logic [2*SW-1:0] S_data_ram_size;
    logic [15:0]     stat_rd_count, stat_wr_count, stat_to_count;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned exp_rd = 0, exp_wr = 0, exp_to = 0;

    always #5 clock = ~clock;

    mem_slave_initiator #(
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .SIZE_W         (SW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_write       (cmd_write),
        .cmd_chan        (cmd_chan),
        .cmd_addr        (cmd_addr),
        .cmd_size        (cmd_size),
        .cmd_wdata       (cmd_wdata),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_rdata       (rsp_rdata),
        .rsp_err         (rsp_err),
        .S_oe_ram        (S_oe_ram),
        .S_we_ram        (S_we_ram),
        .S_addr_ram      (S_addr_ram),
        .S_Wdata_ram     (S_Wdata_ram),
        .S_data_ram_size (S_data_ram_size),
        .Sout_Rdata_ram  (Sout_Rdata_ram),
        .Sout_DataRdy    (Sout_DataRdy),
        .stat_rd_count   (stat_rd_count),
        .stat_wr_count   (stat_wr_count),
        .stat_to_count   (stat_to_count)
    );

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic model_legal(input int unsigned size, input int unsigned addr);
        if (!(size == 8 || size == 16 || size == 32 || size == 64)) return 1'b0;
        return (addr % (size / 8)) == 0;
    endfunction

    function automatic logic [63:0] model_mask(input int unsigned size);
        if (size >= 64) return '1;
        return (64'd1 << size) - 64'd1;
    endfunction

    task automatic check_bus(input string tag, input logic act, input logic wr, input logic ch,
                             input logic [AW-1:0] a, input logic [SW-1:0] sz,
                             input logic [DW-1:0] wd);
        logic [1:0]      e_oe, e_we;
        logic [2*AW-1:0] e_a;
        logic [2*DW-1:0] e_d;
        logic [2*SW-1:0] e_s;
        int c;
        c = ch ? 1 : 0;
        e_oe = '0; e_we = '0; e_a = '0; e_d = '0; e_s = '0;
        if (act) begin
            e_oe[c]            = !wr;
            e_we[c]            = wr;
            e_a[c*AW +: AW]    = a;
            e_d[c*DW +: DW]    = wd & model_mask(32'(sz));
            e_s[c*SW +: SW]    = sz;
        end
        check_val({tag, "_oe"}, 128'(S_oe_ram), 128'(e_oe));
        check_val({tag, "_we"}, 128'(S_we_ram), 128'(e_we));
        check_val({tag, "_addr"}, 128'(S_addr_ram), 128'(e_a));
        check_val({tag, "_wdata"}, 128'(S_Wdata_ram), 128'(e_d));
        check_val({tag, "_size"}, 128'(S_data_ram_size), 128'(e_s));
    endtask

    task automatic check_stats();
`ifdef SLAVE_INIT_STATS_EN
        check_val("stat_rd", 128'(stat_rd_count), 128'(exp_rd));
        check_val("stat_wr", 128'(stat_wr_count), 128'(exp_wr));
        check_val("stat_to", 128'(stat_to_count), 128'(exp_to));
`else
        check_val("stat_rd", 128'(stat_rd_count), 128'(0));
        check_val("stat_wr", 128'(stat_wr_count), 128'(0));
        check_val("stat_to", 128'(stat_to_count), 128'(0));
`endif
    endtask

    // lat: WAIT cycle (1-based) on which the slave answers; 0 means never.
    task automatic do_txn(input logic wr, input logic ch, input logic [AW-1:0] a,
                          input logic [SW-1:0] sz, input logic [DW-1:0] wd,
                          input int unsigned lat, input logic [DW-1:0] rd,
                          input int unsigned hold);
        logic legal, ok, e_err;
        logic [DW-1:0] e_rdata;
        int c;
        c = ch ? 1 : 0;
        legal = model_legal(32'(sz), 32'(a));
        check_val("cmd_ready_idle", 128'(cmd_ready), 128'(1'b1));
        cmd_valid = 1'b1; cmd_write = wr; cmd_chan = ch;
        cmd_addr = a; cmd_size = sz; cmd_wdata = wd;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        cmd_wdata = {$urandom, $urandom};
        cmd_addr  = AW'($urandom);
        if (!legal) begin
            e_err = 1'b1;
            e_rdata = '0;
        end else begin
            ok = (lat >= 1) && (lat <= TO);
            for (int w = 1; w <= int'(TO); w++) begin
                check_bus("bus_wait", 1'b1, wr, ch, a, sz, wd);
                check_val("rsp_valid_wait", 128'(rsp_valid), 128'(1'b0));
                check_val("cmd_ready_wait", 128'(cmd_ready), 128'(1'b0));
                Sout_Rdata_ram = {$urandom, $urandom, $urandom, $urandom};
                Sout_DataRdy = '0;
                Sout_DataRdy[1-c] = 1'($urandom_range(0, 1));
                if (w == int'(lat)) begin
                    Sout_DataRdy[c] = 1'b1;
                    Sout_Rdata_ram[c*DW +: DW] = rd;
                end
                @(posedge clock); #1;
                Sout_DataRdy = '0;
                if (w == int'(lat)) break;
            end
            if (ok) begin
                e_err = 1'b0;
                e_rdata = wr ? '0 : (rd & model_mask(32'(sz)));
                if (wr) exp_wr++; else exp_rd++;
            end else begin
                e_err = 1'b1;
                e_rdata = '0;
                exp_to++;
            end
        end
        check_val("rsp_valid", 128'(rsp_valid), 128'(1'b1));
        check_val("rsp_err", 128'(rsp_err), 128'(e_err));
        check_val("rsp_rdata", 128'(rsp_rdata), 128'(e_rdata));
        check_bus("bus_resp", 1'b0, wr, ch, a, sz, wd);
        for (int h = 0; h < int'(hold); h++) begin
            rsp_ready = 1'b0;
            Sout_DataRdy = 2'($urandom_range(0, 3));
            Sout_Rdata_ram = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clock); #1;
            Sout_DataRdy = '0;
            check_val("hold_valid", 128'(rsp_valid), 128'(1'b1));
            check_val("hold_err", 128'(rsp_err), 128'(e_err));
            check_val("hold_rdata", 128'(rsp_rdata), 128'(e_rdata));
            check_val("hold_cmd_ready", 128'(cmd_ready), 128'(1'b0));
            check_bus("bus_hold", 1'b0, wr, ch, a, sz, wd);
        end
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        rsp_ready = 1'b0;
        check_val("handoff_valid", 128'(rsp_valid), 128'(1'b0));
        check_val("handoff_cmd_ready", 128'(cmd_ready), 128'(1'b1));
        check_stats();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned sizes [10] = '{8, 16, 32, 64, 8, 16, 32, 64, 24, 0};
        int unsigned sz;
        logic [AW-1:0] a;

        reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_chan = 1'b0;
        cmd_addr = '0; cmd_size = '0; cmd_wdata = '0; rsp_ready = 1'b0;
        Sout_DataRdy = '0; Sout_Rdata_ram = '0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock); #1;
        check_val("reset_cmd_ready", 128'(cmd_ready), 128'(1'b1));
        check_val("reset_rsp_valid", 128'(rsp_valid), 128'(1'b0));
        check_val("reset_rsp_err", 128'(rsp_err), 128'(1'b0));
        check_val("reset_rsp_rdata", 128'(rsp_rdata), 128'(0));
        check_bus("reset_bus", 1'b0, 1'b0, 1'b0, '0, '0, '0);
        check_stats();

        do_txn(1'b1, 1'b0, 10'h010, 7'd32, 64'hDEADBEEF_CAFEF00D, 3, '0, 0);
        do_txn(1'b0, 1'b1, 10'h020, 7'd16, '0, 2, 64'h1234_5678_9ABC_DEF0, 0);
        do_txn(1'b0, 1'b0, 10'h000, 7'd24, '0, 1, 64'hFFFF, 0);
        do_txn(1'b1, 1'b1, 10'h003, 7'd32, 64'h55, 1, '0, 0);
        do_txn(1'b0, 1'b1, 10'h040, 7'd64, '0, 0, '0, 0);
        do_txn(1'b0, 1'b0, 10'h008, 7'd64, '0, TO, 64'hA5A5_0000_FFFF_1234, 0);
        do_txn(1'b0, 1'b0, 10'h018, 7'd8, '0, 1, 64'h0102_0304_0506_0708, 5);

        // Abandon a transaction mid-WAIT with reset.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_chan = 1'b1;
        cmd_addr = 10'h100; cmd_size = 7'd32; cmd_wdata = '0;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        exp_rd = 0; exp_wr = 0; exp_to = 0;
        check_bus("midreset_bus", 1'b0, 1'b0, 1'b0, '0, '0, '0);
        check_val("midreset_rsp_valid", 128'(rsp_valid), 128'(1'b0));
        check_val("midreset_cmd_ready", 128'(cmd_ready), 128'(1'b1));
        check_stats();
        do_txn(1'b1, 1'b1, 10'h030, 7'd32, 64'h0BAD_F00D_1234_5678, 2, '0, 1);

        for (int n = 0; n < 60; n++) begin
            sz = sizes[$urandom_range(0, 9)];
            a = AW'($urandom);
            if ($urandom_range(0, 3) != 0 && sz >= 8) a = a & ~AW'(sz / 8 - 1);
            do_txn(1'($urandom), 1'($urandom), a, SW'(sz), {$urandom, $urandom},
                   $urandom_range(0, 10), {$urandom, $urandom}, $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_slave_initiator.md
Name: mem_slave_initiator

Overview:
- Drives the 2-channel HLS accelerator slave memory port (S_oe_ram/S_we_ram/S_addr_ram/S_Wdata_ram/S_data_ram_size, returning Sout_Rdata_ram/Sout_DataRdy) from a simple command/response handshake.
- Used by simulation harnesses and on-chip loaders to preload inputs and read back results of `main` around a start/done run.
- One transaction in flight, on one selected channel. Adds size/alignment checks and a timeout.

Parameters:
- ADDR_W, 10, per-channel address width (S_addr_ram = 2*ADDR_W).
- DATA_W, 64, per-channel data width (S_Wdata_ram/Sout_Rdata_ram = 2*DATA_W).
- SIZE_W, 7, per-channel size field width in bits (S_data_ram_size = 2*SIZE_W).
- TIMEOUT_CYCLES, 256, maximum WAIT cycles before abort; must be ≥1.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_write  in  1  1=write, 0=read.
- cmd_chan  in  1  target channel 0/1.
- cmd_addr  in  ADDR_W  byte address.
- cmd_size  in  SIZE_W  access size in bits: 8/16/32/64.
- cmd_wdata  in  DATA_W  write data, LSB-aligned.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_W  read data, zero-extended to size; 0 for writes and errors.
- rsp_err  out  1  1=illegal size, misaligned, or timeout.
- S_oe_ram  out  2  read enable per channel.
- S_we_ram  out  2  write enable per channel.
- S_addr_ram  out  2*ADDR_W  address; channel c in slice [c*ADDR_W +: ADDR_W].
- S_Wdata_ram  out  2*DATA_W  write data per channel.
- S_data_ram_size  out  2*SIZE_W  size per channel.
- Sout_Rdata_ram  in  2*DATA_W  read data per channel.
- Sout_DataRdy  in  2  completion per channel.
- stat_rd_count, stat_wr_count, stat_to_count  out  16 each  statistics (see Optional Feature).

Behaviour:
- Reset:
  - State goes to IDLE.
  - All S_* outputs are 0; rsp_valid=0; rsp_err=0; rsp_rdata=0; cmd_ready=1 in the cycle after reset deasserts.
  - Stats counters are 0.
  - Reset during WAIT/RESP abandons the transaction: outputs are 0 on the next edge and no response is issued.
- FSM states IDLE, WAIT, RESP:
  - IDLE: cmd_ready=1.
    - Accept on cmd_valid&cmd_ready at edge T.
    - Illegal size or misaligned (cmd_addr mod cmd_size/8 ≠ 0): go to RESP with rsp_err=1. No bus activity.
    - Legal: go to WAIT. From T+1, the selected channel drives oe (read) or we (write), addr, size and wdata, with wdata masked to the size. Other-channel slices stay 0.
  - WAIT: hold all bus signals stable.
    - Sout_DataRdy[chan]=1 at edge T+k:
      - Read: capture the chan slice of Sout_Rdata_ram masked to the size.
      - Bus outputs go to 0 and rsp_valid=1 from T+k+1.
      - Minimum command-to-response latency is 2 cycles.
    - Timeout counter counts WAIT cycles. After TIMEOUT_CYCLES cycles with no DataRdy: deassert the bus, then RESP with rsp_err=1 and rdata=0.
    - If DataRdy and expiry fall on the same cycle, DataRdy wins.
    - DataRdy on the non-selected channel is ignored.
  - RESP: rsp_valid, rsp_rdata and rsp_err are held stable until rsp_valid&rsp_ready.
    - Then go to IDLE; rsp_valid=0 next cycle.
    - No back-to-back bypass: the next command is accepted one cycle after response handoff at the earliest.
- DataRdy in IDLE/RESP is ignored.
- Size mask = (1<<cmd_size)-1; for 64 the mask is all ones, with no shift overflow.

Optional Feature:
- Macro SLAVE_INIT_STATS_EN.
- Defined:
  - stat_rd_count increments on each successful read completion.
  - stat_wr_count increments on each successful write completion.
  - stat_to_count increments on each timeout.
  - All three are 16-bit saturating at 16'hFFFF, cleared by reset.
  - Illegal/misaligned commands count nowhere.
- Undefined: the three ports are tied to 0 and the counters are not instantiated.

Decomposition:
- Shared package mem_slave_pkg holds:
  - state enum (IDLE/WAIT/RESP);
  - legal size constants 8/16/32/64;
  - function size_mask(size) → DATA_W mask;
  - function is_aligned(addr, size).
- Sub-module mem_slave_timeout: loadable down-counter with expire flag.
- Everything else lives in the top.

Test Plan:
- Write chan0 addr 0x010, size 32, wdata 0xDEADBEEF_CAFEF00D:
  - S_we_ram=2'b01, S_Wdata_ram[63:0]=0x00000000_CAFEF00D, S_data_ram_size[6:0]=32, held until DataRdy;
  - model asserts DataRdy after 3 cycles → rsp_valid 1 cycle later with err=0.
- Read chan1 addr 0x020, size 16; model returns 0x1234_5678_9ABC_DEF0 on chan1 slice:
  - S_oe_ram=2'b10;
  - rsp_rdata=0xDEF0, err=0; chan0 slices stay 0 throughout.
- cmd_size=24 or addr 0x003 with size 32:
  - no S_* activity; rsp_valid 1 cycle after accept with err=1, rdata=0.
- No DataRdy with TIMEOUT_CYCLES=8:
  - bus deasserts after 8 WAIT cycles, then err=1;
  - with SLAVE_INIT_STATS_EN, stat_to_count=1.
- rsp_ready held low 5 cycles:
  - rsp fields stable, cmd_ready=0;
  - stray DataRdy ignored;
  - accept proceeds after handoff.
- Reset asserted mid-WAIT:
  - next cycle all S_*=0, rsp_valid=0;
  - a later command completes normally.
